// File: rtl/mgmt_gpio_in_sync.sv
// Management GPIO input conditioning. Each bit passes through a 2-flop
// synchroniser and a programmable debounce filter. A committed level change
// sets a sticky pending flag when its edge direction is enabled. The pending
// flags that are not masked are ORed into one registered, level-sensitive
// interrupt for the management core.
module mgmt_gpio_in_sync #(
  parameter int WIDTH = 19,
  parameter int DEB_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] gpio_in,
  input  logic [DEB_W-1:0] deb_limit,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] irq_mask,
  input  logic [WIDTH-1:0] pend_clr,
  output logic [WIDTH-1:0] gpio_sync,
  output logic [WIDTH-1:0] gpio_deb,
  output logic [WIDTH-1:0] pending,
  output logic             irq
);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [DEB_W-1:0] cnt_q [WIDTH];
  logic [DEB_W-1:0] cnt_d [WIDTH];
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] commit;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  // Two-stage synchroniser for the asynchronous pad inputs
  always_comb begin
    s1_d   = gpio_in;
    sync_d = s1_q;
  end

  // Per-bit debounce: a level must differ from the committed state for
  // deb_limit+1 consecutive cycles before it is committed. Any return to
  // the committed level restarts the count.
  always_comb begin
    deb_d  = deb_q;
    commit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == deb_limit) begin
        deb_d[i]  = sync_q[i];
        cnt_d[i]  = '0;
        commit[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + DEB_W'(1);
      end
    end
  end

  // Edge classification and sticky pending flags. A new event wins over
  // a clear pulse in the same cycle, so no edge is lost.
  always_comb begin
    rise   = commit & sync_q;
    fall   = commit & ~sync_q;
    pend_d = (pend_q & ~pend_clr) | (rise & rise_en) | (fall & fall_en);
    irq_d  = |(pend_q & ~irq_mask);
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_q   <= '0;
      sync_q <= '0;
      deb_q  <= '0;
      pend_q <= '0;
      irq_q  <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q   <= s1_d;
      sync_q <= sync_d;
      deb_q  <= deb_d;
      pend_q <= pend_d;
      irq_q  <= irq_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign gpio_sync = sync_q;
  assign gpio_deb  = deb_q;
  assign pending   = pend_q;
  assign irq       = irq_q;

endmodule
